// File: rtl/ram_arb_pkg.sv
// Shared types, defaults and helpers for the two-port RAM arbiter.
package ram_arb_pkg;

   localparam int ADDR_W_DEF = 4;
   localparam int DATA_W_DEF = 8;

   typedef logic port_id_t;

   localparam port_id_t PORT0 = 1'b0;
   localparam port_id_t PORT1 = 1'b1;

   // Saturating increment; callers pass counters of at most 32 bits.
   function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
      if (val == max_val) begin
         return val;
      end else begin
         return val + 32'd1;
      end
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant logic with the last-granted register.
module rr_arb2
   import ram_arb_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req0,
   input  logic req1,
   output logic gnt0,
   output logic gnt1
);

   port_id_t last_q;
   port_id_t last_d;

   // Grant selection: on conflict the port not granted last wins.
   always_comb begin
      gnt0   = 1'b0;
      gnt1   = 1'b0;
      last_d = last_q;
      if (rst) begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end else if (req0 && req1) begin
         if (last_q == PORT0) begin
            gnt1 = 1'b1;
         end else begin
            gnt0 = 1'b1;
         end
      end else if (req0) begin
         gnt0 = 1'b1;
      end else if (req1) begin
         gnt1 = 1'b1;
      end else begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end
      if (gnt0) begin
         last_d = PORT0;
      end else if (gnt1) begin
         last_d = PORT1;
      end else begin
         last_d = last_q;
      end
   end

   // Last-granted register; resets to port 1 so port 0 wins the first conflict.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= PORT1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/ram_arb_2p.sv
// Round-robin arbiter/sequencer sharing one single-port sync RAM between two requesters.
// Optional statistics counters are built when RAM_ARB_STATS_EN is defined.
module ram_arb_2p
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
`ifdef RAM_ARB_STATS_EN
   ,
   parameter int CNT_W  = 16
`endif
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] din0,
   input  logic [DATA_W-1:0] din1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] dout0,
   output logic [DATA_W-1:0] dout1,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout
`ifdef RAM_ARB_STATS_EN
   ,
   input  logic              stat_clr,
   output logic [CNT_W-1:0]  gnt_cnt0,
   output logic [CNT_W-1:0]  gnt_cnt1,
   output logic [CNT_W-1:0]  conf_cnt
`endif
);

   logic     rd_pend_q;
   logic     rd_pend_d;
   port_id_t rd_owner_q;
   port_id_t rd_owner_d;

   rr_arb2 u_arb (
      .clk  (clk),
      .rst  (rst),
      .req0 (req0),
      .req1 (req1),
      .gnt0 (gnt0),
      .gnt1 (gnt1)
   );

   // RAM port mux and read-return bookkeeping.
   always_comb begin
      ram_en     = 1'b0;
      ram_we     = 1'b0;
      ram_addr   = '0;
      ram_din    = '0;
      rd_pend_d  = 1'b0;
      rd_owner_d = rd_owner_q;
      if (gnt1) begin
         ram_en     = 1'b1;
         ram_we     = we1;
         ram_addr   = addr1;
         ram_din    = din1;
         rd_pend_d  = ~we1;
         rd_owner_d = PORT1;
      end else if (gnt0) begin
         ram_en     = 1'b1;
         ram_we     = we0;
         ram_addr   = addr0;
         ram_din    = din0;
         rd_pend_d  = ~we0;
         rd_owner_d = PORT0;
      end else begin
         rd_pend_d  = 1'b0;
         rd_owner_d = rd_owner_q;
      end
   end

   // Read-pending state; a read issued the cycle before reset is discarded.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_pend_q  <= 1'b0;
         rd_owner_q <= PORT0;
      end else begin
         rd_pend_q  <= rd_pend_d;
         rd_owner_q <= rd_owner_d;
      end
   end

   // Read data returns to whichever port issued last cycle's read.
   always_comb begin
      rvalid0 = rd_pend_q && (rd_owner_q == PORT0);
      rvalid1 = rd_pend_q && (rd_owner_q == PORT1);
      dout0   = ram_dout;
      dout1   = ram_dout;
   end

`ifdef RAM_ARB_STATS_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] gnt_cnt0_q, gnt_cnt0_d;
   logic [CNT_W-1:0] gnt_cnt1_q, gnt_cnt1_d;
   logic [CNT_W-1:0] conf_cnt_q, conf_cnt_d;

   // Saturating statistics; clear wins over increment.
   always_comb begin
      gnt_cnt0_d = gnt_cnt0_q;
      gnt_cnt1_d = gnt_cnt1_q;
      conf_cnt_d = conf_cnt_q;
      if (stat_clr) begin
         gnt_cnt0_d = '0;
         gnt_cnt1_d = '0;
         conf_cnt_d = '0;
      end else begin
         if (gnt0) begin
            gnt_cnt0_d = CNT_W'(sat_inc(32'(gnt_cnt0_q), 32'(CNT_MAX)));
         end else begin
            gnt_cnt0_d = gnt_cnt0_q;
         end
         if (gnt1) begin
            gnt_cnt1_d = CNT_W'(sat_inc(32'(gnt_cnt1_q), 32'(CNT_MAX)));
         end else begin
            gnt_cnt1_d = gnt_cnt1_q;
         end
         if (req0 && req1) begin
            conf_cnt_d = CNT_W'(sat_inc(32'(conf_cnt_q), 32'(CNT_MAX)));
         end else begin
            conf_cnt_d = conf_cnt_q;
         end
      end
   end

   // Statistics registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_cnt0_q <= '0;
         gnt_cnt1_q <= '0;
         conf_cnt_q <= '0;
      end else begin
         gnt_cnt0_q <= gnt_cnt0_d;
         gnt_cnt1_q <= gnt_cnt1_d;
         conf_cnt_q <= conf_cnt_d;
      end
   end

   assign gnt_cnt0 = gnt_cnt0_q;
   assign gnt_cnt1 = gnt_cnt1_q;
   assign conf_cnt = conf_cnt_q;
`endif

endmodule

// File: tb/tb_ram_arb_2p.sv
// Directed table-driven bench for ram_arb_2p with a write-first 16x8 RAM model.
module tb_ram_arb_2p;

   logic       clk;
   logic       rst;
   logic       req0, req1, we0, we1;
   logic [3:0] addr0, addr1;
   logic [7:0] din0, din1;
   logic       gnt0, gnt1, rvalid0, rvalid1;
   logic [7:0] dout0, dout1;
   logic       ram_en, ram_we;
   logic [3:0] ram_addr;
   logic [7:0] ram_din;
   logic [7:0] ram_dout;
   logic       preload;
   logic [7:0] mem [16];

   int checks = 0;
   int errors = 0;

   ram_arb_2p dut (
      .clk      (clk),
      .rst      (rst),
      .req0     (req0),
      .req1     (req1),
      .we0      (we0),
      .we1      (we1),
      .addr0    (addr0),
      .addr1    (addr1),
      .din0     (din0),
      .din1     (din1),
      .gnt0     (gnt0),
      .gnt1     (gnt1),
      .rvalid0  (rvalid0),
      .rvalid1  (rvalid1),
      .dout0    (dout0),
      .dout1    (dout1),
      .ram_en   (ram_en),
      .ram_we   (ram_we),
      .ram_addr (ram_addr),
      .ram_din  (ram_din),
      .ram_dout (ram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] init_val(input int i);
      case (i)
         0:       return 8'h11;
         1:       return 8'd45;
         2:       return 8'h22;
         14:      return 8'hE0;
         default: return 8'h00;
      endcase
   endfunction

   // Write-first single-port RAM model.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
      end else if (ram_en) begin
         if (ram_we) begin
            mem[ram_addr] <= ram_din;
            ram_dout      <= ram_din;
         end else begin
            ram_dout <= mem[ram_addr];
         end
      end
   end

   typedef struct {
      logic       rst;
      logic       req0; logic we0; logic [3:0] a0; logic [7:0] d0;
      logic       req1; logic we1; logic [3:0] a1; logic [7:0] d1;
      logic       g0;   logic g1;  logic en;  logic we;
      logic [3:0] addr; logic [7:0] din;
      logic       rv0;  logic rv1; logic [7:0] dout;
   } vec_t;

   localparam int NV = 18;
   vec_t vec [NV];
   vec_t seq [4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic apply(input string tag, input vec_t v);
      @(negedge clk);
      rst = v.rst;
      req0 = v.req0; we0 = v.we0; addr0 = v.a0; din0 = v.d0;
      req1 = v.req1; we1 = v.we1; addr1 = v.a1; din1 = v.d1;
      #1;
      check({tag, " gnt0"},     32'(gnt0),     32'(v.g0));
      check({tag, " gnt1"},     32'(gnt1),     32'(v.g1));
      check({tag, " ram_en"},   32'(ram_en),   32'(v.en));
      check({tag, " ram_we"},   32'(ram_we),   32'(v.we));
      check({tag, " ram_addr"}, 32'(ram_addr), 32'(v.addr));
      check({tag, " ram_din"},  32'(ram_din),  32'(v.din));
      check({tag, " rvalid0"},  32'(rvalid0),  32'(v.rv0));
      check({tag, " rvalid1"},  32'(rvalid1),  32'(v.rv1));
      if (v.rv0) check({tag, " dout0"}, 32'(dout0), 32'(v.dout));
      if (v.rv1) check({tag, " dout1"}, 32'(dout1), 32'(v.dout));
   endtask

   initial begin
      //          rst  req0 we0  a0    d0      req1 we1  a1    d1     g0   g1   en   we   addr  din     rv0  rv1  dout
      vec[0]  = '{1'b1,1'b0,1'b0,4'd0, 8'h00, 1'b0,1'b0,4'd0, 8'h00, 1'b0,1'b0,1'b0,1'b0,4'd0, 8'h00, 1'b0,1'b0,8'h00};
      vec[1]  = '{1'b1,1'b1,1'b0,4'd1, 8'h00, 1'b0,1'b0,4'd0, 8'h00, 1'b0,1'b0,1'b0,1'b0,4'd0, 8'h00, 1'b0,1'b0,8'h00};
      vec[2]  = '{1'b0,1'b0,1'b0,4'd0, 8'h00, 1'b0,1'b0,4'd0, 8'h00, 1'b0,1'b0,1'b0,1'b0,4'd0, 8'h00, 1'b0,1'b0,8'h00};
      vec[3]  = '{1'b0,1'b1,1'b0,4'd1, 8'h5A, 1'b0,1'b0,4'd0, 8'h00, 1'b1,1'b0,1'b1,1'b0,4'd1, 8'h5A, 1'b0,1'b0,8'h00};
      vec[4]  = '{1'b0,1'b0,1'b0,4'd0, 8'h00, 1'b0,1'b0,4'd0, 8'h00, 1'b0,1'b0,1'b0,1'b0,4'd0, 8'h00, 1'b1,1'b0,8'd45};
      vec[5]  = '{1'b0,1'b0,1'b0,4'd0, 8'h00, 1'b1,1'b1,4'd15,8'd89, 1'b0,1'b1,1'b1,1'b1,4'd15,8'd89, 1'b0,1'b0,8'h00};
      vec[6]  = '{1'b0,1'b0,1'b0,4'd0, 8'h00, 1'b1,1'b0,4'd15,8'h00, 1'b0,1'b1,1'b1,1'b0,4'd15,8'h00, 1'b0,1'b0,8'h00};
      vec[7]  = '{1'b0,1'b0,1'b0,4'd0, 8'h00, 1'b0,1'b0,4'd0, 8'h00, 1'b0,1'b0,1'b0,1'b0,4'd0, 8'h00, 1'b0,1'b1,8'd89};
      vec[8]  = '{1'b1,1'b1,1'b0,4'd0, 8'h00, 1'b1,1'b0,4'd14,8'h00, 1'b0,1'b0,1'b0,1'b0,4'd0, 8'h00, 1'b0,1'b0,8'h00};
      vec[9]  = '{1'b0,1'b1,1'b0,4'd0, 8'h00, 1'b1,1'b0,4'd14,8'h00, 1'b1,1'b0,1'b1,1'b0,4'd0, 8'h00, 1'b0,1'b0,8'h00};
      vec[10] = '{1'b0,1'b1,1'b0,4'd0, 8'h00, 1'b1,1'b0,4'd14,8'h00, 1'b0,1'b1,1'b1,1'b0,4'd14,8'h00, 1'b1,1'b0,8'h11};
      vec[11] = '{1'b0,1'b1,1'b0,4'd0, 8'h00, 1'b1,1'b0,4'd14,8'h00, 1'b1,1'b0,1'b1,1'b0,4'd0, 8'h00, 1'b0,1'b1,8'hE0};
      vec[12] = '{1'b0,1'b1,1'b0,4'd0, 8'h00, 1'b1,1'b0,4'd14,8'h00, 1'b0,1'b1,1'b1,1'b0,4'd14,8'h00, 1'b1,1'b0,8'h11};
      vec[13] = '{1'b0,1'b1,1'b0,4'd0, 8'h00, 1'b0,1'b0,4'd0, 8'h00, 1'b1,1'b0,1'b1,1'b0,4'd0, 8'h00, 1'b0,1'b1,8'hE0};
      vec[14] = '{1'b0,1'b1,1'b0,4'd1, 8'h00, 1'b0,1'b0,4'd0, 8'h00, 1'b1,1'b0,1'b1,1'b0,4'd1, 8'h00, 1'b1,1'b0,8'h11};
      vec[15] = '{1'b0,1'b1,1'b0,4'd2, 8'h00, 1'b0,1'b0,4'd0, 8'h00, 1'b1,1'b0,1'b1,1'b0,4'd2, 8'h00, 1'b1,1'b0,8'd45};
      vec[16] = '{1'b0,1'b0,1'b0,4'd0, 8'h00, 1'b0,1'b0,4'd0, 8'h00, 1'b0,1'b0,1'b0,1'b0,4'd0, 8'h00, 1'b1,1'b0,8'h22};
      vec[17] = '{1'b0,1'b0,1'b0,4'd0, 8'h00, 1'b0,1'b0,4'd0, 8'h00, 1'b0,1'b0,1'b0,1'b0,4'd0, 8'h00, 1'b0,1'b0,8'h00};

      // Conflict on addr 3 with a pending write: port 1 reads old data, then port 0 writes, then port 1 re-reads.
      seq[0]  = '{1'b0,1'b1,1'b1,4'd3, 8'h77, 1'b1,1'b0,4'd3, 8'h00, 1'b0,1'b1,1'b1,1'b0,4'd3, 8'h00, 1'b0,1'b0,8'h00};
      seq[1]  = '{1'b0,1'b1,1'b1,4'd3, 8'h77, 1'b0,1'b0,4'd0, 8'h00, 1'b1,1'b0,1'b1,1'b1,4'd3, 8'h77, 1'b0,1'b1,8'h00};
      seq[2]  = '{1'b0,1'b0,1'b0,4'd0, 8'h00, 1'b1,1'b0,4'd3, 8'h00, 1'b0,1'b1,1'b1,1'b0,4'd3, 8'h00, 1'b0,1'b0,8'h00};
      seq[3]  = '{1'b0,1'b0,1'b0,4'd0, 8'h00, 1'b0,1'b0,4'd0, 8'h00, 1'b0,1'b0,1'b0,1'b0,4'd0, 8'h00, 1'b0,1'b1,8'h77};

      rst = 1'b1; preload = 1'b1;
      req0 = 1'b0; we0 = 1'b0; addr0 = 4'd0; din0 = 8'h00;
      req1 = 1'b0; we1 = 1'b0; addr1 = 4'd0; din1 = 8'h00;
      @(negedge clk);
      preload = 1'b0;

      for (int i = 0; i < NV; i++) apply($sformatf("vec%0d", i), vec[i]);
      for (int i = 0; i < 4; i++) apply($sformatf("seq%0d", i), seq[i]);

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
